dummy_accelerator_issuer: RTL



---
 rtl/dummy_accelerator_pkg.sv | 21 ++
 rtl/dummy_accelerator_wdog_cnt.sv | 35 +++
 rtl/dummy_accelerator_issuer.sv | 114 +++++++++++
 3 files changed

// File: rtl/dummy_accelerator_pkg.sv
// Shared types for the dummy accelerator issuer: FSM state encoding and request layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package dummy_accelerator_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultCtlWidth  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } dummy_acc_state_e;

  // Request as presented to the accelerator upstream port (default widths).
  typedef struct packed {
    logic [DefaultCtlWidth-1:0]  ctl;
    logic [DefaultDataWidth-1:0] data;
  } dummy_acc_req_t;

endpackage

// File: rtl/dummy_accelerator_wdog_cnt.sv
// Watchdog counter: clear/enable up-counter, saturating, with terminal-count flag.
// Latency: tc_o is combinational from the registered count (high while count == TimeoutCycles-1).
// Backpressure: none; en_i simply stalls the count.
// Ports: clk_i/rst_ni clock and async active-low reset, clr_i synchronous clear,
//        en_i count enable, tc_o terminal count (tied low when TimeoutCycles == 0).
module dummy_accelerator_wdog_cnt #(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  // Keep at least one bit so a disabled watchdog still elaborates cleanly.
  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned TcValue  = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CntWidth'(TimeoutCycles))) begin
      // Saturate at TimeoutCycles so a stuck enable can never wrap back to tc.
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign tc_o = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TcValue));

endmodule

// File: rtl/dummy_accelerator_issuer.sv
// Core-side initiator: takes one command, issues it to the accelerator, buffers the result.
// Latency: best case cmd at cycle 0, result handshake cycle 1, res_valid_o cycle 2.
// Backpressure: cmd_ready_o low until the buffered result is taken; watchdog aborts hung ops.
// Ports: cmd_* command in, acc_* accelerator request/result, acc_flush_o abort pulse,
//        res_* buffered result out (res_err_o marks a watchdog-generated result).
module dummy_accelerator_issuer
  import dummy_accelerator_pkg::*;
#(
  parameter int unsigned DataWidth     = DefaultDataWidth,
  parameter int unsigned CtlWidth      = DefaultCtlWidth,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [CtlWidth-1:0]  cmd_ctl_i,
  input  logic [DataWidth-1:0] cmd_data_i,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic [CtlWidth-1:0]  acc_ctl_o,
  output logic [DataWidth-1:0] acc_data_o,
  input  logic                 acc_res_valid_i,
  output logic                 acc_res_ready_o,
  input  logic [DataWidth-1:0] acc_res_data_i,
  output logic                 acc_flush_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [DataWidth-1:0] res_data_o,
  output logic                 res_err_o
);

  // Same layout as dummy_acc_req_t, sized to this instance's widths.
  typedef struct packed {
    logic [CtlWidth-1:0]  ctl;
    logic [DataWidth-1:0] data;
  } req_t;

  dummy_acc_state_e     state_q;
  req_t                 req_q;
  logic [DataWidth-1:0] res_data_q;
  logic                 res_err_q;
  logic                 wdog_tc;
  logic                 timeout;

  // A multicycle accelerator never raises acc_ready_i; requests retire on the result handshake.
  logic unused_acc_ready;
  assign unused_acc_ready = acc_ready_i;

  // Counter is held clear outside ISSUE, so it always starts from 0 on entry.
  dummy_accelerator_wdog_cnt #(
    .TimeoutCycles(TimeoutCycles)
  ) u_wdog_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (state_q != ST_ISSUE),
    .en_i  (state_q == ST_ISSUE),
    .tc_o  (wdog_tc)
  );

  // A result arriving on the terminal cycle wins over the timeout.
  assign timeout = (state_q == ST_ISSUE) && wdog_tc && !acc_res_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else if (flush_i) begin
      // Abort beats every transition; any command offered this cycle is dropped.
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            req_q   <= '{ctl: cmd_ctl_i, data: cmd_data_i};
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (acc_res_valid_i) begin
            res_data_q <= acc_res_data_i;
            res_err_q  <= 1'b0;
            state_q    <= ST_DRAIN;
          end else if (timeout) begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
            state_q    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (res_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from state only; the flush is the single Mealy output.
  assign cmd_ready_o     = (state_q == ST_IDLE);
  assign acc_valid_o     = (state_q == ST_ISSUE);
  assign acc_res_ready_o = (state_q == ST_ISSUE);
  assign res_valid_o     = (state_q == ST_DRAIN);
  assign acc_ctl_o       = req_q.ctl;
  assign acc_data_o      = req_q.data;
  assign res_data_o      = res_data_q;
  assign res_err_o       = res_err_q;
  assign acc_flush_o     = flush_i | timeout;

endmodule
